// File: rtl/psg_pkg.sv
// Shared definitions for the PSG register bank: bus modes, register
// indices and the per-register implemented-bit masks.
package psg_pkg;

    // Bus mode as sampled from {bdir, bc1}, with BC2 tied high.
    typedef enum logic [1:0] {
        MODE_INACTIVE = 2'b00,
        MODE_READ     = 2'b01,
        MODE_WRITE    = 2'b10,
        MODE_LATCH    = 2'b11
    } bus_mode_e;

    localparam logic [3:0] REG_TONE_A_LO = 4'd0;
    localparam logic [3:0] REG_TONE_A_HI = 4'd1;
    localparam logic [3:0] REG_TONE_B_LO = 4'd2;
    localparam logic [3:0] REG_TONE_B_HI = 4'd3;
    localparam logic [3:0] REG_TONE_C_LO = 4'd4;
    localparam logic [3:0] REG_TONE_C_HI = 4'd5;
    localparam logic [3:0] REG_NOISE     = 4'd6;
    localparam logic [3:0] REG_MIXER     = 4'd7;
    localparam logic [3:0] REG_AMP_A     = 4'd8;
    localparam logic [3:0] REG_AMP_B     = 4'd9;
    localparam logic [3:0] REG_AMP_C     = 4'd10;
    localparam logic [3:0] REG_ENV_LO    = 4'd11;
    localparam logic [3:0] REG_ENV_HI    = 4'd12;
    localparam logic [3:0] REG_ENV_SHAPE = 4'd13;

    // Implemented bits of each register; everything else stores and reads 0.
    function automatic logic [7:0] reg_mask(input logic [3:0] addr);
        logic [7:0] m;
        case (addr)
            REG_TONE_A_HI, REG_TONE_B_HI, REG_TONE_C_HI, REG_ENV_SHAPE: m = 8'h0F;
            REG_NOISE, REG_AMP_A, REG_AMP_B, REG_AMP_C:                 m = 8'h1F;
            default:                                                    m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/psg_bus_decode.sv
// Bus front end: decodes {bdir,bc1}, holds the latched register address and
// chip-select, and generates the one-cycle envelope restart pulse.
module psg_bus_decode
    import psg_pkg::*;
#(
    parameter logic [3:0] CHIP_ADDR_HI = 4'b0000,
    parameter logic [3:0] RESET_ADDR   = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bdir,
    input  logic       bc1,
    input  logic [7:0] data_in,
    output bus_mode_e  mode,
    output logic [3:0] addr,
    output logic       selected,
    output logic       env_restart
);

    logic [3:0] addr_q, addr_d;
    logic       selected_q, selected_d;
    bus_mode_e  prev_mode_q, prev_mode_d;
    logic       env_restart_q, env_restart_d;

    assign mode        = bus_mode_e'({bdir, bc1});
    assign addr        = addr_q;
    assign selected    = selected_q;
    assign env_restart = env_restart_q;

    // Next-state: address/select latch and first-write-to-R13 edge detect.
    // The address only moves in latch mode, so a previous write cycle always
    // had the same address; checking the previous mode alone is sufficient.
    always_comb begin
        addr_d        = addr_q;
        selected_d    = selected_q;
        prev_mode_d   = mode;
        env_restart_d = 1'b0;
        if (mode == MODE_LATCH) begin
            addr_d     = data_in[3:0];
            selected_d = (data_in[7:4] == CHIP_ADDR_HI);
        end
        if ((mode == MODE_WRITE) && selected_q && (addr_q == REG_ENV_SHAPE) &&
            (prev_mode_q != MODE_WRITE)) begin
            env_restart_d = 1'b1;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q        <= RESET_ADDR;
            selected_q    <= 1'b1;
            prev_mode_q   <= MODE_INACTIVE;
            env_restart_q <= 1'b0;
        end else begin
            addr_q        <= addr_d;
            selected_q    <= selected_d;
            prev_mode_q   <= prev_mode_d;
            env_restart_q <= env_restart_d;
        end
    end

endmodule

// File: rtl/psg_register_file.sv
// PSG register bank: sixteen bus-writable registers, registered read port
// and the control fields consumed by the tone, noise and envelope blocks.
module psg_register_file
    import psg_pkg::*;
#(
    parameter logic [3:0] CHIP_ADDR_HI = 4'b0000,
    parameter logic [3:0] RESET_ADDR   = 4'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bdir,
    input  logic        bc1,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic [11:0] tone_period_a,
    output logic [11:0] tone_period_b,
    output logic [11:0] tone_period_c,
    output logic [4:0]  noise_period,
    output logic [5:0]  mixer_n,
    output logic [4:0]  amp_a,
    output logic [4:0]  amp_b,
    output logic [4:0]  amp_c,
    output logic [15:0] env_period,
    output logic [3:0]  env_shape,
    output logic        env_restart
);

    bus_mode_e  mode;
    logic [3:0] addr;
    logic       selected;

    logic [7:0] regs_q [16];
    logic [7:0] regs_d [16];
    logic [7:0] data_out_q, data_out_d;
    logic       data_oe_q, data_oe_d;

    psg_bus_decode #(
        .CHIP_ADDR_HI (CHIP_ADDR_HI),
        .RESET_ADDR   (RESET_ADDR)
    ) u_decode (
        .clk         (clk),
        .rst_n       (rst_n),
        .bdir        (bdir),
        .bc1         (bc1),
        .data_in     (data_in),
        .mode        (mode),
        .addr        (addr),
        .selected    (selected),
        .env_restart (env_restart)
    );

    // Next-state: masked register write and registered read mux.
    always_comb begin
        regs_d     = regs_q;
        data_out_d = 8'h00;
        data_oe_d  = 1'b0;
        if ((mode == MODE_WRITE) && selected) begin
            regs_d[addr] = data_in & reg_mask(addr);
        end
        if ((mode == MODE_READ) && selected) begin
            data_out_d = regs_q[addr] & reg_mask(addr);
            data_oe_d  = 1'b1;
        end
    end

    // Register bank and read port with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q     <= '{default: 8'h00};
            data_out_q <= 8'h00;
            data_oe_q  <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
        end
    end

    assign data_out      = data_out_q;
    assign data_oe       = data_oe_q;
    assign tone_period_a = {regs_q[REG_TONE_A_HI][3:0], regs_q[REG_TONE_A_LO]};
    assign tone_period_b = {regs_q[REG_TONE_B_HI][3:0], regs_q[REG_TONE_B_LO]};
    assign tone_period_c = {regs_q[REG_TONE_C_HI][3:0], regs_q[REG_TONE_C_LO]};
    assign noise_period  = regs_q[REG_NOISE][4:0];
    assign mixer_n       = regs_q[REG_MIXER][5:0];
    assign amp_a         = regs_q[REG_AMP_A][4:0];
    assign amp_b         = regs_q[REG_AMP_B][4:0];
    assign amp_c         = regs_q[REG_AMP_C][4:0];
    assign env_period    = {regs_q[REG_ENV_HI], regs_q[REG_ENV_LO]};
    assign env_shape     = regs_q[REG_ENV_SHAPE][3:0];

endmodule

// File: tb/tb_psg_register_file.sv
// Bench for psg_register_file: a table of bus cycles with expected results,
// a queue-based scoreboard, and hand sequences for reset and env_restart.
module tb_psg_register_file;

    localparam logic [1:0] M_I = 2'b00;
    localparam logic [1:0] M_R = 2'b01;
    localparam logic [1:0] M_W = 2'b10;
    localparam logic [1:0] M_L = 2'b11;

    // Observed quantities
    localparam int C_NONE = 0, C_RD = 1, C_TA = 2, C_MIX = 3, C_SHP = 4,
                   C_NOI = 5, C_AMPA = 6, C_ENVP = 7, C_RST = 8, C_TB = 9, C_TC = 10;

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  din;
        int          chk;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        int          chk;
        logic [15:0] exp;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bdir = 1'b0;
    logic        bc1 = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [11:0] tone_period_a, tone_period_b, tone_period_c;
    logic [4:0]  noise_period, amp_a, amp_b, amp_c;
    logic [5:0]  mixer_n;
    logic [15:0] env_period;
    logic [3:0]  env_shape;
    logic        env_restart;

    int checks = 0;
    int failures = 0;
    vec_t vecs[$];
    sb_t  sb[$];

    psg_register_file dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bdir          (bdir),
        .bc1           (bc1),
        .data_in       (data_in),
        .data_out      (data_out),
        .data_oe       (data_oe),
        .tone_period_a (tone_period_a),
        .tone_period_b (tone_period_b),
        .tone_period_c (tone_period_c),
        .noise_period  (noise_period),
        .mixer_n       (mixer_n),
        .amp_a         (amp_a),
        .amp_b         (amp_b),
        .amp_c         (amp_c),
        .env_period    (env_period),
        .env_shape     (env_shape),
        .env_restart   (env_restart)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] observe(int chk);
        case (chk)
            C_RD:    return {7'd0, data_oe, data_out};
            C_TA:    return {4'd0, tone_period_a};
            C_MIX:   return {10'd0, mixer_n};
            C_SHP:   return {12'd0, env_shape};
            C_NOI:   return {11'd0, noise_period};
            C_AMPA:  return {11'd0, amp_a};
            C_ENVP:  return env_period;
            C_RST:   return {15'd0, env_restart};
            C_TB:    return {4'd0, tone_period_b};
            C_TC:    return {4'd0, tone_period_c};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic string cname(int chk);
        case (chk)
            C_RD:    return "read{oe,data}";
            C_TA:    return "tone_period_a";
            C_MIX:   return "mixer_n";
            C_SHP:   return "env_shape";
            C_NOI:   return "noise_period";
            C_AMPA:  return "amp_a";
            C_ENVP:  return "env_period";
            C_RST:   return "env_restart";
            C_TB:    return "tone_period_b";
            C_TC:    return "tone_period_c";
            default: return "none";
        endcase
    endfunction

    task automatic compare(input string tag, input int chk, input logic [15:0] exp);
        logic [15:0] act;
        act = observe(chk);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s %s got=%h want=%h", tag, cname(chk), act, exp);
        end else begin
            $display("ok   %s %s = %h", tag, cname(chk), act);
        end
    endtask

    // One bus cycle: drive at negedge, push expectation, compare after posedge.
    task automatic step(input logic [1:0] mode, input logic [7:0] din,
                        input int chk, input logic [15:0] exp);
        sb_t e;
        @(negedge clk);
        {bdir, bc1} = mode;
        data_in = din;
        if (chk != C_NONE) begin
            e.chk = chk;
            e.exp = exp;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (chk != C_NONE) begin
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL scoreboard empty got=0 want=1");
            end else begin
                e = sb.pop_front();
                compare($sformatf("cyc mode=%b din=%h", mode, din), e.chk, e.exp);
            end
        end
    endtask

    initial begin
        // Main table: starts from reset state (addr 0, selected).
        vecs.push_back('{M_L, 8'h01, C_NONE, 16'h0000});
        vecs.push_back('{M_W, 8'hFF, C_TA,   16'h0F00});
        vecs.push_back('{M_L, 8'h00, C_NONE, 16'h0000});
        vecs.push_back('{M_W, 8'h34, C_TA,   16'h0F34});
        vecs.push_back('{M_L, 8'h01, C_NONE, 16'h0000});
        vecs.push_back('{M_R, 8'h00, C_RD,   16'h010F});
        vecs.push_back('{M_I, 8'h00, C_RD,   16'h0000});
        vecs.push_back('{M_L, 8'h17, C_NONE, 16'h0000});
        vecs.push_back('{M_W, 8'h55, C_MIX,  16'h0000});
        vecs.push_back('{M_R, 8'h00, C_RD,   16'h0000});
        vecs.push_back('{M_L, 8'h07, C_NONE, 16'h0000});
        vecs.push_back('{M_W, 8'h3F, C_MIX,  16'h003F});
        vecs.push_back('{M_W, 8'hFF, C_MIX,  16'h003F});
        vecs.push_back('{M_R, 8'h00, C_RD,   16'h01FF});
        vecs.push_back('{M_L, 8'h06, C_NONE, 16'h0000});
        vecs.push_back('{M_W, 8'hFF, C_NOI,  16'h001F});
        vecs.push_back('{M_R, 8'h00, C_RD,   16'h011F});
        vecs.push_back('{M_L, 8'h08, C_NONE, 16'h0000});
        vecs.push_back('{M_W, 8'hFF, C_AMPA, 16'h001F});
        vecs.push_back('{M_R, 8'h00, C_RD,   16'h011F});
        vecs.push_back('{M_L, 8'h0C, C_NONE, 16'h0000});
        vecs.push_back('{M_W, 8'hFF, C_ENVP, 16'hFF00});
        vecs.push_back('{M_R, 8'h00, C_RD,   16'h01FF});
        vecs.push_back('{M_L, 8'h03, C_NONE, 16'h0000});
        vecs.push_back('{M_W, 8'hAB, C_TB,   16'h0B00});
        vecs.push_back('{M_L, 8'h02, C_NONE, 16'h0000});
        vecs.push_back('{M_W, 8'h12, C_TB,   16'h0B12});
        vecs.push_back('{M_L, 8'h05, C_NONE, 16'h0000});
        vecs.push_back('{M_W, 8'hC7, C_TC,   16'h0700});
        vecs.push_back('{M_L, 8'h0E, C_NONE, 16'h0000});
        vecs.push_back('{M_W, 8'hA5, C_NONE, 16'h0000});
        vecs.push_back('{M_R, 8'h00, C_RD,   16'h01A5});
        vecs.push_back('{M_L, 8'h00, C_NONE, 16'h0000});
        vecs.push_back('{M_R, 8'h00, C_RD,   16'h0134});

        // Reset state, checked while rst_n is still low.
        #12;
        compare("reset", C_TA, 16'h0000);
        compare("reset", C_RD, 16'h0000);
        compare("reset", C_RST, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].mode, vecs[i].din, vecs[i].chk, vecs[i].exp);
        end

        // Held write to R13: one pulse; rewrite after a gap pulses again.
        step(M_L, 8'h0D, C_RST, 16'h0000);
        step(M_W, 8'h0A, C_RST, 16'h0001);
        step(M_W, 8'h0A, C_RST, 16'h0000);
        step(M_W, 8'h0A, C_RST, 16'h0000);
        step(M_W, 8'h0A, C_SHP, 16'h000A);
        step(M_I, 8'h00, C_RST, 16'h0000);
        step(M_W, 8'h0A, C_RST, 16'h0001);
        step(M_I, 8'h00, C_RST, 16'h0000);
        step(M_R, 8'h00, C_RD,  16'h010A);

        // Asynchronous reset mid-cycle while a read is active.
        step(M_L, 8'h01, C_NONE, 16'h0000);
        step(M_R, 8'h00, C_RD,   16'h010F);
        #2;
        rst_n = 1'b0;
        #1;
        compare("async_reset", C_RD, 16'h0000);
        compare("async_reset", C_TA, 16'h0000);
        compare("async_reset", C_ENVP, 16'h0000);
        compare("async_reset", C_MIX, 16'h0000);
        @(negedge clk);
        {bdir, bc1} = M_I;
        rst_n = 1'b1;

        // Reset asserted across a write to R0: write is lost, addr back to 0.
        step(M_L, 8'h00, C_NONE, 16'h0000);
        @(negedge clk);
        {bdir, bc1} = M_W;
        data_in = 8'h80;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        compare("reset_mid_write", C_TA, 16'h0000);
        @(negedge clk);
        {bdir, bc1} = M_I;
        rst_n = 1'b1;
        step(M_I, 8'h00, C_TA, 16'h0000);
        step(M_R, 8'h00, C_RD, 16'h0100);
        step(M_W, 8'h22, C_TA, 16'h0022);

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
